// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory port between instruction fetch and data access.
// Optional MEM_ARB_ROUND_ROBIN_EN: ties alternate instead of always favouring the data port.

typedef struct packed {
   logic [31:0] addr;
   logic [31:0] data;
   logic [3:0]  do_read;
   logic [3:0]  do_write;
   logic        valid;
} memory_io_req;

typedef struct packed {
   logic [31:0] data;
   logic        valid;
   logic        ready;
} memory_io_rsp;

localparam memory_io_req memory_io_no_req32 = '{
   addr: 32'h0, data: 32'h0, do_read: 4'h0, do_write: 4'h0, valid: 1'b0
};

module mem_port_arbiter (
   input  logic         clk,
   input  logic         reset,
   input  memory_io_req inst_req,
   output memory_io_rsp inst_rsp,
   input  memory_io_req data_req,
   output memory_io_rsp data_rsp,
   output memory_io_req mem_req,
   input  memory_io_rsp mem_rsp
);

   // Handshake: a requester's req is accepted in the cycle where req.valid and
   // its rsp.ready are both high; the matching rsp.valid pulses exactly once later.

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;
   typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

   arb_state_t state_q, state_d;
   owner_t     owner_q, owner_d;
   grant_t     last_grant_q, last_grant_d;
   logic       idle_ready;
   logic       pick_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWN_NONE;
         last_grant_q <= GRANT_INST;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      pick_data = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_data = data_req.valid && (!inst_req.valid || (last_grant_q == GRANT_INST));
`else
      pick_data = data_req.valid;
`endif
   end

   assign idle_ready = (state_q == ARB_IDLE) && mem_rsp.ready && !reset;

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      last_grant_d   = last_grant_q;
      mem_req        = memory_io_no_req32;
      inst_rsp.data  = mem_rsp.data;
      inst_rsp.valid = 1'b0;
      inst_rsp.ready = idle_ready;
      data_rsp.data  = mem_rsp.data;
      data_rsp.valid = 1'b0;
      data_rsp.ready = idle_ready;

      case (state_q)
         ARB_IDLE: begin
            // A response seen here has no owner and is dropped.
            if (idle_ready && (inst_req.valid || data_req.valid)) begin
               state_d = ARB_BUSY;
               if (pick_data) begin
                  mem_req      = data_req;
                  owner_d      = OWN_DATA;
                  last_grant_d = GRANT_DATA;
               end else begin
                  mem_req      = inst_req;
                  owner_d      = OWN_INST;
                  last_grant_d = GRANT_INST;
               end
            end
         end
         ARB_BUSY: begin
            if (mem_rsp.valid && !reset) begin
               inst_rsp.valid = (owner_q == OWN_INST);
               data_rsp.valid = (owner_q == OWN_DATA);
               state_d        = ARB_IDLE;
               owner_d        = OWN_NONE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected events queued by the driver,
// popped and compared by a monitor whenever a valid appears on any output.

module tb_mem_port_arbiter;

   localparam int W = 74;
   localparam logic [1:0] K_REQ  = 2'd0;
   localparam logic [1:0] K_INST = 2'd1;
   localparam logic [1:0] K_DATA = 2'd2;

   logic         clk = 1'b0;
   logic         reset;
   memory_io_req inst_req, data_req, mem_req;
   memory_io_rsp inst_rsp, data_rsp, mem_rsp;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .inst_req (inst_req),
      .inst_rsp (inst_rsp),
      .data_req (data_req),
      .data_rsp (data_rsp),
      .mem_req  (mem_req),
      .mem_rsp  (mem_rsp)
   );

   function automatic memory_io_req rd(input logic [31:0] a);
      rd = '{addr: a, data: 32'h0, do_read: 4'hF, do_write: 4'h0, valid: 1'b1};
   endfunction

   function automatic memory_io_req wr(input logic [31:0] a, input logic [31:0] d);
      wr = '{addr: a, data: d, do_read: 4'h0, do_write: 4'hF, valid: 1'b1};
   endfunction

   function automatic logic [W-1:0] req_word(input memory_io_req r);
      req_word = {K_REQ, r.addr, r.data, r.do_read, r.do_write};
   endfunction

   function automatic logic [W-1:0] rsp_word(input logic [1:0] k, input logic [31:0] d);
      rsp_word = {k, 32'h0, d, 8'h0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_pop(input string name, input logic [W-1:0] act);
      logic [W-1:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event %h with nothing expected", name, act);
      end else begin
         exp = exp_q.pop_front();
         if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
         end
      end
   endtask

   // Monitor: every valid on an output must match the next expected event.
   always @(negedge clk) begin
      if (mem_req.valid)
         check_pop("mem_req", {K_REQ, mem_req.addr, mem_req.data, mem_req.do_read, mem_req.do_write});
      if (inst_rsp.valid)
         check_pop("inst_rsp", rsp_word(K_INST, inst_rsp.data));
      if (data_rsp.valid)
         check_pop("data_rsp", rsp_word(K_DATA, data_rsp.data));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_mem(input logic v, input logic r, input logic [31:0] d);
      mem_rsp = '{data: d, valid: v, ready: r};
   endtask

   task automatic check_ready(input string name, input logic exp);
      check({name, "_inst_ready"}, {31'h0, inst_rsp.ready}, {31'h0, exp});
      check({name, "_data_ready"}, {31'h0, data_rsp.ready}, {31'h0, exp});
   endtask

   initial begin
      logic win_data;
      memory_io_req ir, dr;

      reset    = 1'b1;
      inst_req = rd(32'hF00);
      data_req = memory_io_no_req32;
      set_mem(1'b0, 1'b1, 32'h0);

      // Reset: nothing forwarded, no ready, no response even with mem valid.
      sample();
      check_ready("rst", 1'b0);
      check("rst_mem_valid", {31'h0, mem_req.valid}, 32'h0);
      step();
      set_mem(1'b1, 1'b1, 32'h1234);
      sample();
      check("rst_inst_valid", {31'h0, inst_rsp.valid}, 32'h0);
      check("rst_data_valid", {31'h0, data_rsp.valid}, 32'h0);

      // Single fetch, response three cycles after grant.
      step();
      reset    = 1'b0;
      set_mem(1'b0, 1'b1, 32'h0);
      inst_req = rd(32'h100);
      exp_q.push_back(req_word(rd(32'h100)));
      sample();
      check("fetch_addr", mem_req.addr, 32'h100);
      check_ready("fetch_grant", 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         inst_req = memory_io_no_req32;
         sample();
         check_ready("fetch_busy", 1'b0);
      end
      step();
      set_mem(1'b1, 1'b1, 32'h00500093);
      exp_q.push_back(rsp_word(K_INST, 32'h00500093));
      sample();
      check("fetch_rsp_valid", {31'h0, inst_rsp.valid}, 32'h1);
      check("fetch_rsp_data", inst_rsp.data, 32'h00500093);
      check("fetch_other_valid", {31'h0, data_rsp.valid}, 32'h0);
      step();
      set_mem(1'b0, 1'b1, 32'h0);
      sample();
      check("fetch_single_pulse", {31'h0, inst_rsp.valid}, 32'h0);
      check_ready("fetch_after", 1'b1);

      // Store held for five cycles while a fetch waits.
      step();
      data_req = wr(32'h2000, 32'hDEADBEEF);
      exp_q.push_back(req_word(wr(32'h2000, 32'hDEADBEEF)));
      sample();
      check("store_grant_ready", {31'h0, data_rsp.ready}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         step();
         data_req = memory_io_no_req32;
         inst_req = rd(32'h300);
         sample();
         check_ready("store_busy", 1'b0);
         check("store_busy_mem_valid", {31'h0, mem_req.valid}, 32'h0);
      end
      step();
      set_mem(1'b1, 1'b1, 32'h11112222);
      exp_q.push_back(rsp_word(K_DATA, 32'h11112222));
      sample();
      check("store_rsp_valid", {31'h0, data_rsp.valid}, 32'h1);
      check("store_fetch_held", {31'h0, mem_req.valid}, 32'h0);
      step();
      set_mem(1'b0, 1'b1, 32'h0);
      exp_q.push_back(req_word(rd(32'h300)));
      sample();
      check("waiting_fetch_addr", mem_req.addr, 32'h300);
      step();
      inst_req = memory_io_no_req32;
      set_mem(1'b1, 1'b1, 32'hA5A50300);
      exp_q.push_back(rsp_word(K_INST, 32'hA5A50300));
      sample();

      // Ties: last_grant is inst here, so round-robin starts with data.
      for (int i = 0; i < 4; i++) begin
         step();
         set_mem(1'b0, 1'b1, 32'h0);
         ir = rd(32'h400 + 32'(i * 4));
         dr = rd(32'h800 + 32'(i * 4));
         inst_req = ir;
         data_req = dr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         win_data = (i % 2 == 0);
`else
         win_data = 1'b1;
`endif
         exp_q.push_back(req_word(win_data ? dr : ir));
         sample();
         check("tie_grant_addr", mem_req.addr, win_data ? dr.addr : ir.addr);
         step();
         inst_req = memory_io_no_req32;
         data_req = memory_io_no_req32;
         set_mem(1'b1, 1'b1, 32'hC0DE0000 + 32'(i));
         exp_q.push_back(rsp_word(win_data ? K_DATA : K_INST, 32'hC0DE0000 + 32'(i)));
         sample();
      end
      step();
      set_mem(1'b0, 1'b1, 32'h0);
      inst_req = rd(32'h440);
      exp_q.push_back(req_word(rd(32'h440)));
      sample();
      check("tie_fetch_after", mem_req.addr, 32'h440);
      step();
      inst_req = memory_io_no_req32;
      set_mem(1'b1, 1'b1, 32'h44004400);
      exp_q.push_back(rsp_word(K_INST, 32'h44004400));
      sample();

      // Reset while busy: the late response is dropped.
      step();
      set_mem(1'b0, 1'b1, 32'h0);
      inst_req = rd(32'h500);
      exp_q.push_back(req_word(rd(32'h500)));
      sample();
      step();
      inst_req = memory_io_no_req32;
      reset    = 1'b1;
      sample();
      check_ready("midrst", 1'b0);
      step();
      reset = 1'b0;
      sample();
      check_ready("midrst_idle", 1'b1);
      step();
      set_mem(1'b1, 1'b1, 32'hBAD0BAD0);
      sample();
      check("midrst_inst_valid", {31'h0, inst_rsp.valid}, 32'h0);
      check("midrst_data_valid", {31'h0, data_rsp.valid}, 32'h0);
      step();
      set_mem(1'b0, 1'b1, 32'h0);
      inst_req = rd(32'h600);
      exp_q.push_back(req_word(rd(32'h600)));
      sample();
      check("midrst_next_addr", mem_req.addr, 32'h600);
      step();
      inst_req = memory_io_no_req32;
      set_mem(1'b1, 1'b1, 32'h00600600);
      exp_q.push_back(rsp_word(K_INST, 32'h00600600));
      sample();

      // Backpressure, then release with a stray response in the grant cycle.
      for (int i = 0; i < 10; i++) begin
         step();
         set_mem(1'b0, 1'b0, 32'h0);
         inst_req = rd(32'h700);
         data_req = rd(32'h900);
         sample();
         check("bp_mem_valid", {31'h0, mem_req.valid}, 32'h0);
         check_ready("bp", 1'b0);
      end
      step();
      set_mem(1'b1, 1'b1, 32'hFEEDFEED);
      // last_grant is inst, so both priority modes pick data here.
      exp_q.push_back(req_word(rd(32'h900)));
      sample();
      check("bp_release_valid", {31'h0, mem_req.valid}, 32'h1);
      check("bp_stray_inst", {31'h0, inst_rsp.valid}, 32'h0);
      check("bp_stray_data", {31'h0, data_rsp.valid}, 32'h0);
      step();
      inst_req = memory_io_no_req32;
      data_req = memory_io_no_req32;
      set_mem(1'b1, 1'b1, 32'h90909090);
      exp_q.push_back(rsp_word(K_DATA, 32'h90909090));
      sample();
      check("bp_rsp_valid", {31'h0, data_rsp.valid}, 32'h1);
      step();
      set_mem(1'b0, 1'b1, 32'h0);
      sample();
      check("queue_drained", exp_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
